// File: rtl/rr_prio_encoder.sv
// rr_prio_encoder: registered round-robin priority encoder with valid/ready output stage.
// Optional multi-hot checking enabled by defining RR_ENC_ONEHOT_CHECK_EN.
module rr_prio_encoder #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_none,
  output logic         out_multi,
  output logic         err_sticky
);
  logic [W-1:0] ptr, lo_hi, lo_all, grant;
  logic [N-1:0] hi_req;
  logic         accept, any;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign any      = |in_req;
  // Requests at or above ptr win first; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_req = '0;
    lo_hi  = '0;
    lo_all = '0;
    for (int i = 0; i < N; i++) hi_req[i] = in_req[i] && (W'(i) >= ptr);
    for (int i = N - 1; i >= 0; i--) begin
      lo_hi  = hi_req[i] ? W'(i) : lo_hi;
      lo_all = in_req[i] ? W'(i) : lo_all;
    end
    grant = (|hi_req) ? lo_hi : lo_all;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_none   <= 1'b0;
      ptr        <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_none   <= !any;
      out_idx    <= any ? grant : '0;
      out_onehot <= any ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
      if (any) ptr <= (grant == W'(N - 1)) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef RR_ENC_ONEHOT_CHECK_EN
  logic multi;
  assign multi = |(in_req & (in_req - 1'b1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_multi  <= 1'b0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      out_multi  <= multi;
      err_sticky <= err_sticky || multi;
    end
  end
`else
  assign out_multi  = 1'b0;
  assign err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_rr_prio_encoder.sv
// tb_rr_prio_encoder: directed and randomized checks against a behavioural round-robin model.
module tb_rr_prio_encoder;
  localparam int N = 64;
  localparam int W = 6;
`ifdef RR_ENC_ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [N-1:0] in_req = '0;
  logic in_ready, out_valid, out_none, out_multi, err_sticky;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  int checks = 0, errors = 0;

  rr_prio_encoder #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_req(in_req), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_onehot(out_onehot),
    .out_none(out_none), .out_multi(out_multi), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Reference: an explicit circular scan from ptr, plus a mirror of the held result.
  int m_ptr;
  bit m_valid, m_none, m_multi, m_err;
  int m_idx;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_none = 0; m_multi = 0; m_err = 0; m_idx = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      int g;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && in_req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      m_valid = 1;
      m_none  = (g < 0);
      m_idx   = (g < 0) ? 0 : g;
      m_multi = CHK && ($countones(in_req) > 1);
      m_err   = m_err || m_multi;
      if (g >= 0) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("valid", N'(out_valid), N'(m_valid));
    cmp("err_sticky", N'(err_sticky), N'(m_err));
    if (!reset) cmp("in_ready", N'(in_ready), N'(!m_valid || out_ready));
    if (m_valid && !reset) begin
      cmp("idx", N'(out_idx), N'(m_idx));
      cmp("onehot", out_onehot, m_none ? '0 : (N'(1) << m_idx));
      cmp("none", N'(out_none), N'(m_none));
      cmp("multi", N'(out_multi), N'(m_multi));
    end
  end

  task automatic step(input logic v, input logic [N-1:0] req, input logic rdy);
    in_valid = v; in_req = req; out_ready = rdy;
    @(posedge clk); #2;
  endtask

  initial begin
    logic [N-1:0] r;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    cmp("rst_valid", N'(out_valid), 0);
    cmp("rst_idx", N'(out_idx), 0);
    // round-robin over two requesters
    step(1, 64'h11, 1); cmp("t1_idx0", N'(out_idx), 0); cmp("t1_oh0", out_onehot, 64'h1);
    step(1, 64'h11, 1); cmp("t1_idx1", N'(out_idx), 4); cmp("t1_oh1", out_onehot, 64'h10);
    step(1, 64'h11, 1); cmp("t1_idx2", N'(out_idx), 0); cmp("t1_oh2", out_onehot, 64'h1);
    // top bit wraps ptr to 0
    step(1, 64'h8000_0000_0000_0000, 1); cmp("t2_idx", N'(out_idx), 63);
    cmp("t2_oh", out_onehot, 64'h8000_0000_0000_0000);
    step(1, 64'h3, 1); cmp("t2_wrap", N'(out_idx), 0);
    // empty request leaves ptr at 1
    step(1, 64'h0, 1); cmp("t3_none", N'(out_none), 1); cmp("t3_valid", N'(out_valid), 1);
    cmp("t3_oh", out_onehot, 0);
    step(1, 64'h3, 1); cmp("t3_ptr", N'(out_idx), 1);
    // multi-hot flag
    step(1, 64'h6, 1); cmp("t5_idx", N'(out_idx), 2); cmp("t5_multi", N'(out_multi), N'(CHK));
    step(0, 64'h0, 1); cmp("t5_drain", N'(out_valid), 0); cmp("t5_err", N'(err_sticky), N'(CHK));
    // backpressure then full throughput
    step(1, 64'h10, 0); cmp("t4_idx", N'(out_idx), 4);
    repeat (3) begin
      step(1, 64'hFF, 0);
      cmp("t4_ready", N'(in_ready), 0); cmp("t4_hold", N'(out_idx), 4);
    end
    step(1, 64'hFF, 1); cmp("t4_n0", N'(out_idx), 5);
    step(1, 64'hFF, 1); cmp("t4_n1", N'(out_idx), 6); cmp("t4_nobubble", N'(out_valid), 1);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: r = {$urandom, $urandom};
      endcase
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0);
    end
    // asynchronous reset mid-stream
    step(1, 64'h30, 1);
    step(1, 64'h30, 1);
    reset = 1;
    #1 cmp("t6_async", N'(out_valid), 0);
    cmp("t6_err", N'(err_sticky), 0);
    @(posedge clk); #2 reset = 0;
    step(1, 64'h3, 1); cmp("t6_restart", N'(out_idx), 0);
    step(0, 64'h0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
